// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit with its sequencing FSM.
// One shift-add (multiply) or one restoring-subtract (divide) step per cycle.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  // state | meaning
  // IDLE  | waiting for an M-extension op from EX
  // BUSY  | iterating, one step per cycle, XLEN steps
  // DONE  | result presented for one cycle, pipeline released

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic              neg_res;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] acc;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   spec_val;
  logic              neg_acc;

  // Accept-cycle decode: operand magnitudes, sign flags and special cases
  always_comb begin
    a_signed = funct3[2] ? ~funct3[0] : (funct3 != 3'b011);
    b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
    a_neg    = a_signed & src_a[XLEN-1];
    b_neg    = b_signed & src_b[XLEN-1];
    abs_a    = a_neg ? -src_a : src_a;
    abs_b    = b_neg ? -src_b : src_b;
    div_zero = funct3[2] & (src_b == '0);
    div_ovf  = funct3[2] & ~funct3[0] & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (&src_b);
    special  = div_zero | div_ovf;
    // remainder ops: src_a on /0, zero on overflow; quotient ops: all ones on /0, src_a on overflow
    if (funct3[1]) spec_val = div_zero ? src_a : '0;
    else           spec_val = div_zero ? '1 : src_a;
    // remainder follows the dividend sign, product/quotient the sign difference
    neg_acc  = (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);
  end

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     trial;
  logic              trial_ge;
  logic [XLEN-1:0]   new_rem;
  logic [2*XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fin;

  // One iteration step plus the sign fix-up and result select of the final value
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
    trial    = acc[2*XLEN-1:XLEN-1];
    trial_ge = trial >= {1'b0, mag_b};
    new_rem  = trial_ge ? (trial[XLEN-1:0] - mag_b) : trial[XLEN-1:0];
    if (op[2]) step_acc = {new_rem, acc[XLEN-2:0], trial_ge};
    else       step_acc = {mul_sum, acc[XLEN-1:1]};
    prod = neg_res ? -step_acc : step_acc;
    quo  = neg_res ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    rem  = neg_res ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
    case (op)
      3'b000:                 fin = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin = quo;
      default:                fin = rem;
    endcase
  end

  // Sequencer FSM and datapath registers; flush always wins and returns to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      neg_res <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      result  <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_valid) begin
            op      <= funct3;
            mag_a   <= abs_a;
            mag_b   <= abs_b;
            neg_res <= neg_acc;
            acc     <= {{XLEN{1'b0}}, (funct3[2] ? abs_a : abs_b)};
            cnt     <= '0;
            if (special) begin
              result <= spec_val;
              state  <= DONE;
            end else begin
              state  <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= step_acc;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            result <= fin;
            cnt    <= '0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall covers the accept cycle and all of BUSY; flush releases it immediately
  always_comb begin
    stall        = ~flush & ((state == BUSY) | ((state == IDLE) & issue_valid));
    result_valid = ~flush & (state == DONE);
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit and its controlling FSM, in the EX stage beside the main ALU.
- Accepts one M-extension operation from EX and stalls IF/ID/EX while it iterates.
- Presents a one-cycle result to the EX/MEM register.
- One shift-add or one restoring-subtract step per cycle, so the datapath holds a single adder.

Parameters:
XLEN, 32, operand/result width; supported values 32 and 64 (64 is for the regression sweep only).
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
issue_valid  input  1  EX holds an M-extension op (opcode 0110011, funct7=0000001)
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a  input  XLEN  rs1 value
src_b  input  XLEN  rs2 value
flush  input  1  branch/jump flush of EX; aborts the operation
stall  output  1  freeze PC, IF/ID and ID/EX
result_valid  output  1  result valid this cycle
result  output  XLEN  rd write value

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, all internal registers cleared, stall=0, result_valid=0, result=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - issue_valid=1 and flush=0: the op is accepted.
  - In the accept cycle, latch funct3, operand magnitudes, sign flags and special-case flags.
  - stall=1 combinationally in the accept cycle.
  - Next state is BUSY, or DONE if a special case applies.
- Special cases, no iteration:
  - Divide by zero (src_b=0): DIV/DIVU quotient = all ones; REM/REMU remainder = src_a.
  - Signed overflow (DIV/REM, src_a=100..0, src_b=all ones): quotient = src_a, remainder = 0.
  - Special-case ops reach DONE 1 cycle after accept.
- BUSY:
  - Exactly XLEN cycles, counter 0..XLEN-1; stall=1 throughout.
  - Multiply: 2*XLEN-bit product register, add multiplicand when the multiplier LSB is 1, shift right by 1.
  - Divide: restoring. Shift {rem, quo} left by 1, trial subtract divisor, keep the result if non-negative and set quo LSB.
  - On counter = XLEN-1, go to DONE.
- Sign handling:
  - Signed operands are converted to magnitudes at accept: MUL/MULH take both signed, MULHSU takes only src_a signed, DIV/REM take both signed.
  - Final fix-up in DONE: product negated if the operand signs differ.
  - Quotient negated if the signs differ; remainder takes the sign of the dividend.
- Result select:
  - MUL: low XLEN bits of the product; MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient; REM/REMU: remainder.
- DONE:
  - result_valid=1 and stall=0 for exactly one cycle; result is driven.
  - Next state is IDLE.
  - result holds its value afterward until the next DONE; result_valid=0 outside DONE.
- Latency: accept at cycle T means normal ops assert result_valid at T+XLEN+1 (T+33 for XLEN=32); special cases at T+1. Stall covers T..T+XLEN.
- Back-to-back issue: the pipeline advances in the DONE cycle, so a new issue_valid is sampled only in IDLE. A dependent MULs pair therefore has a 1-cycle IDLE bubble; there is no accept in DONE.
- flush:
  - Any state: return to IDLE next cycle, drop the result_valid pulse, stall=0 in that cycle.
  - flush with issue_valid in IDLE: not accepted.
  - flush in DONE suppresses result_valid.
- issue_valid must stay stable while stall=1; changes during BUSY are ignored (operands are latched).
- rst_n asserted mid-operation: immediate return to reset values; no partial result is observable.

Test Plan:
- MUL src_a=7, src_b=-3 (0xFFFFFFFD) -> stall high T..T+32, result_valid at T+33, result=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU src_a=-1, src_b=0xFFFFFFFF -> 0xFFFFFFFF; MUL low half -> 0x00000001.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each valid at T+33.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, valid at T+1. DIV 0x80000000/-1 -> 0x80000000; REM of the same pair -> 0.
- Flush asserted at T+10 of a DIV -> stall=0 at T+11, no result_valid pulse. A new MUL 3*4 issued immediately -> result 12 at its accept+33.
- rst_n pulsed low at T+5 of a MUL -> stall, result_valid and result all 0 at once. A following op completes normally.
